// File: rtl/hazard_stall_ctrl.sv
// Stall controller for the five-stage MIPS core: compares D-stage source use times
// against producers in E/M and tracks mult/div unit occupancy.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_b,
  input  logic       d_cal_r,
  input  logic       d_cal_i,
  input  logic       d_load,
  input  logic       d_store,
  input  logic       d_jal,
  input  logic       d_jr,
  input  logic       d_jalr,
  input  logic       d_mf,
  input  logic       d_mdft,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_wa,
  input  logic       d_md_start,
  input  logic       d_md_div,
  output logic       stall,
  output logic       md_busy,
  output logic [3:0] md_count
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [4:0] e_wa_q, e_wa_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic       e_md_start_q, e_md_start_d;
  logic       e_md_div_q, e_md_div_d;
  logic [4:0] m_wa_q, m_wa_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [3:0] md_count_q, md_count_d;

  logic       rs_used, rt_used;
  logic [1:0] rs_tuse, rt_tuse;
  logic [1:0] d_tnew;
  logic       data_stall, md_stall;

  // A source only conflicts when its producer will still be computing after the
  // consumer needs it; $0 is excluded through the wa != 0 term.
  function automatic logic src_hazard(input logic [4:0] src, input logic used,
                                      input logic [1:0] tuse, input logic [4:0] wa,
                                      input logic [1:0] tnew);
    return used && (wa != 5'd0) && (wa == src) && (tnew > tuse);
  endfunction

  function automatic logic [1:0] tnew_after_stage(input logic [1:0] tnew);
    return (tnew != 2'd0) ? tnew - 2'd1 : 2'd0;
  endfunction

  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    rs_tuse = 2'd0;
    rt_tuse = 2'd0;
    if (d_b) begin
      rs_used = 1'b1;
      rt_used = 1'b1;
    end else if (d_jr || d_jalr) begin
      rs_used = 1'b1;
    end else if (d_cal_r) begin
      rs_used = 1'b1;
      rt_used = 1'b1;
      rs_tuse = 2'd1;
      rt_tuse = 2'd1;
    end else if (d_cal_i || d_load) begin
      rs_used = 1'b1;
      rs_tuse = 2'd1;
    end else if (d_store) begin
      rs_used = 1'b1;
      rt_used = 1'b1;
      rs_tuse = 2'd1;
      rt_tuse = 2'd2;
    end
  end

  always_comb begin
    d_tnew = 2'd0;
    if (d_wa != 5'd0) begin
      if (d_load)
        d_tnew = 2'd2;
      else if (d_cal_r || d_cal_i || d_mf)
        d_tnew = 2'd1;
      else if (d_jal || d_jalr)
        d_tnew = 2'd0;
    end
  end

  always_comb begin
    data_stall = src_hazard(d_rs, rs_used, rs_tuse, e_wa_q, e_tnew_q)
               | src_hazard(d_rt, rt_used, rt_tuse, e_wa_q, e_tnew_q)
               | src_hazard(d_rs, rs_used, rs_tuse, m_wa_q, m_tnew_q)
               | src_hazard(d_rt, rt_used, rt_tuse, m_wa_q, m_tnew_q);
    md_stall   = d_mdft && (e_md_start_q || (md_count_q != 4'd0));
    stall      = data_stall || md_stall;
  end

  // D -> E (bubble on stall), E -> M, and mult/div occupancy countdown
  always_comb begin
    e_wa_d       = d_wa;
    e_tnew_d     = d_tnew;
    e_md_start_d = d_md_start;
    e_md_div_d   = d_md_start && d_md_div;
    if (stall) begin
      e_wa_d       = 5'd0;
      e_tnew_d     = 2'd0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
    end

    m_wa_d   = e_wa_q;
    m_tnew_d = tnew_after_stage(e_tnew_q);

    md_count_d = md_count_q;
    if (e_md_start_q)
      md_count_d = e_md_div_q ? DIV_LOAD : MULT_LOAD;
    else if (md_count_q != 4'd0)
      md_count_d = md_count_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_wa_q       <= 5'd0;
      e_tnew_q     <= 2'd0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_wa_q       <= 5'd0;
      m_tnew_q     <= 2'd0;
      md_count_q   <= 4'd0;
    end else begin
      e_wa_q       <= e_wa_d;
      e_tnew_q     <= e_tnew_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      m_wa_q       <= m_wa_d;
      m_tnew_q     <= m_tnew_d;
      md_count_q   <= md_count_d;
    end
  end

  assign md_busy  = (md_count_q != 4'd0);
  assign md_count = md_count_q;

`ifndef SYNTHESIS
  // The MDFT stall keeps a second mult/div out of E while the unit is busy.
  a_no_md_reload : assert property (@(posedge clk) disable iff (!rst_n)
    !(e_md_start_q && (md_count_q != 4'd0)));
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: per-cycle expectations queued at drive
// time and compared against stall/md_busy/md_count on the falling edge.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_b, d_cal_r, d_cal_i, d_load, d_store, d_jal, d_jr, d_jalr, d_mf, d_mdft;
  logic [4:0] d_rs, d_rt, d_wa;
  logic       d_md_start, d_md_div;
  logic       stall, md_busy;
  logic [3:0] md_count;

  typedef struct packed {
    logic       stall;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  string cur_test = "init";
  int    n_vec = 0;
  int    n_err = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_b(d_b), .d_cal_r(d_cal_r), .d_cal_i(d_cal_i), .d_load(d_load),
    .d_store(d_store), .d_jal(d_jal), .d_jr(d_jr), .d_jalr(d_jalr),
    .d_mf(d_mf), .d_mdft(d_mdft), .d_rs(d_rs), .d_rt(d_rt), .d_wa(d_wa),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .md_busy(md_busy), .md_count(md_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic s, input logic [3:0] c);
    exp_t e;
    e.stall = s;
    e.cnt   = c;
    exp_q.push_back(e);
    tag_q.push_back(cur_test);
  endtask

  task automatic sample();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".stall"}, 32'(stall), 32'(e.stall));
    chk({t, ".md_count"}, 32'(md_count), 32'(e.cnt));
    chk({t, ".md_busy"}, 32'(md_busy), 32'(e.cnt != 4'd0));
  endtask

  always @(negedge clk) if (exp_q.size() != 0) sample();

  // One D-stage cycle: queue the expected outputs, then advance past the edge.
  task automatic step(input logic s, input logic [3:0] c);
    push(s, c);
    @(posedge clk);
    #1;
  endtask

  task automatic d_clear();
    {d_b, d_cal_r, d_cal_i, d_load, d_store, d_jal, d_jr, d_jalr, d_mf, d_mdft} = '0;
    d_rs = 5'd0; d_rt = 5'd0; d_wa = 5'd0;
    d_md_start = 1'b0; d_md_div = 1'b0;
  endtask

  task automatic i_nop();                 d_clear(); endtask
  task automatic i_lw(input int rt, input int base);
    d_clear(); d_load = 1'b1; d_rs = 5'(base); d_rt = 5'(rt); d_wa = 5'(rt);
  endtask
  task automatic i_sw(input int rt, input int base);
    d_clear(); d_store = 1'b1; d_rs = 5'(base); d_rt = 5'(rt);
  endtask
  task automatic i_addu(input int rd, input int rs, input int rt);
    d_clear(); d_cal_r = 1'b1; d_rs = 5'(rs); d_rt = 5'(rt); d_wa = 5'(rd);
  endtask
  task automatic i_br(input int rs, input int rt);
    d_clear(); d_b = 1'b1; d_rs = 5'(rs); d_rt = 5'(rt);
  endtask
  task automatic i_jal();                 d_clear(); d_jal = 1'b1; d_wa = 5'd31; endtask
  task automatic i_jr(input int rs);      d_clear(); d_jr = 1'b1; d_rs = 5'(rs); endtask
  task automatic i_md(input logic is_div);
    d_clear(); d_md_start = 1'b1; d_md_div = is_div; d_mdft = 1'b1; d_rs = 5'd6; d_rt = 5'd7;
  endtask
  task automatic i_mf(input int rd);      d_clear(); d_mf = 1'b1; d_mdft = 1'b1; d_wa = 5'(rd); endtask
  task automatic i_mthi(input int rs);    d_clear(); d_mdft = 1'b1; d_rs = 5'(rs); endtask

  task automatic flush();
    i_nop(); step(1'b0, 4'd0); step(1'b0, 4'd0);
  endtask

  initial begin
    d_clear();
    rst_n = 1'b0;
    cur_test = "reset_init";
    #2; push(1'b0, 4'd0); sample();
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush();

    cur_test = "lw_addu";
    i_lw(3, 1); step(1'b0, 4'd0);
    i_addu(4, 3, 5); step(1'b1, 4'd0); step(1'b0, 4'd0);
    flush();

    cur_test = "lw_beq";
    i_lw(3, 1); step(1'b0, 4'd0);
    i_br(3, 0); step(1'b1, 4'd0); step(1'b1, 4'd0); step(1'b0, 4'd0);
    flush();

    cur_test = "lw_nop_beq";
    i_lw(3, 1); step(1'b0, 4'd0);
    i_nop(); step(1'b0, 4'd0);
    i_br(3, 0); step(1'b1, 4'd0); step(1'b0, 4'd0);
    flush();

    cur_test = "lw_r0";
    i_lw(0, 1); step(1'b0, 4'd0);
    i_addu(4, 0, 5); step(1'b0, 4'd0);
    flush();

    cur_test = "lw_sw_rt";
    i_lw(3, 1); step(1'b0, 4'd0);
    i_sw(3, 4); step(1'b0, 4'd0);
    flush();

    cur_test = "lw_sw_rs";
    i_lw(3, 1); step(1'b0, 4'd0);
    i_sw(5, 3); step(1'b1, 4'd0); step(1'b0, 4'd0);
    flush();

    cur_test = "alu_bne";
    i_addu(2, 3, 4); step(1'b0, 4'd0);
    i_br(2, 1); step(1'b1, 4'd0); step(1'b0, 4'd0);
    flush();

    cur_test = "alu_nop_bne";
    i_addu(2, 3, 4); step(1'b0, 4'd0);
    i_nop(); step(1'b0, 4'd0);
    i_br(2, 1); step(1'b0, 4'd0);
    flush();

    cur_test = "jal_jr";
    i_jal(); step(1'b0, 4'd0);
    i_jr(31); step(1'b0, 4'd0);
    flush();

    cur_test = "mult_mflo";
    i_md(1'b0); step(1'b0, 4'd0);
    i_mf(2); step(1'b1, 4'd0);
    for (int k = 5; k >= 1; k--) step(1'b1, 4'(k));
    step(1'b0, 4'd0);
    flush();

    cur_test = "div_mfhi";
    i_md(1'b1); step(1'b0, 4'd0);
    i_mf(3); step(1'b1, 4'd0);
    for (int k = 10; k >= 1; k--) step(1'b1, 4'(k));
    step(1'b0, 4'd0);
    flush();

    cur_test = "div_addu";
    i_md(1'b1); step(1'b0, 4'd0);
    i_addu(4, 5, 6); step(1'b0, 4'd0);
    i_nop();
    for (int k = 10; k >= 1; k--) step(1'b0, 4'(k));
    step(1'b0, 4'd0);
    flush();

    cur_test = "lw_mthi_busy";
    i_md(1'b0); step(1'b0, 4'd0);
    i_nop(); step(1'b0, 4'd0); step(1'b0, 4'd5);
    i_lw(8, 1); step(1'b0, 4'd4);
    i_mthi(8); step(1'b1, 4'd3); step(1'b1, 4'd2); step(1'b1, 4'd1); step(1'b0, 4'd0);
    flush();

    cur_test = "reset_mid";
    i_md(1'b0); step(1'b0, 4'd0);
    i_nop(); step(1'b0, 4'd0);
    i_lw(3, 1); step(1'b0, 4'd5);
    i_addu(4, 3, 5);
    push(1'b1, 4'd4);
    @(negedge clk); #1;
    #1 rst_n = 1'b0;
    #1; push(1'b0, 4'd0); sample();
    @(posedge clk); #1;
    push(1'b0, 4'd0); sample();
    rst_n = 1'b1;
    cur_test = "post_reset";
    step(1'b0, 4'd0);
    flush();

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall controller for the five-stage MIPS core. It consumes the instruction-class flags produced by the decode-stage classifier (B, CAL_R, CAL_I, LOAD, STORE, JAL, JR, JALR, MF, MDFT) together with register addresses. It tracks the producing instructions in E and M, plus the multiply/divide unit occupancy. It drives one stall signal that freezes PC/F/D and inserts a bubble into E.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu/madd/maddu/msub/msubu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_b, d_cal_r, d_cal_i, d_load, d_store, d_jal, d_jr, d_jalr, d_mf, d_mdft  in  1 each  class flags of the instruction in D
- d_rs, d_rt  in  5  source register fields of the D instruction
- d_wa  in  5  destination register of the D instruction (0 = no write)
- d_md_start  in  1  D instruction starts the mult/div unit (mult*, div*, madd*, msub*)
- d_md_div  in  1  qualifies d_md_start: 1 = div/divu
- stall  out  1  freeze PC and F/D; E receives a bubble
- md_busy  out  1  mult/div counter non-zero
- md_count  out  4  remaining mult/div busy cycles

## Operation
- Tuse of the D instruction (0/1/2; none = never stalls):
  - B: rs and rt = 0.
  - JR, JALR: rs = 0.
  - CAL_R: rs and rt = 1.
  - CAL_I, LOAD: rs = 1.
  - STORE: rs = 1, rt = 2.
  - Others: none.
- Tnew at entry to E:
  - LOAD: 2.
  - CAL_R, CAL_I, MF: 1.
  - JAL, JALR: 0.
  - Any instruction with d_wa = 0: 0.
- Internal E record: {wa, tnew, md_start, md_div}. Internal M record: {wa, tnew}.
- Data stall when a stage X in {E, M} meets all of:
  - X.wa != 0;
  - X.wa equals a used source;
  - X.tnew > Tuse of that source.
- Register $0 never causes a stall.
- M-stage tnew is saturating-decremented from E on every transfer, so an M load has tnew 1.
- MD stall: d_mdft & (E.md_start | md_busy).
- stall = data stall | MD stall. It is combinational from the D inputs and the registered E/M/counter state.
- Edge update:
  - E ← bubble if stall, else D info.
  - M ← E with tnew − 1 (floor 0).
- Counter update on each edge:
  - If E.md_start: md_count ← (E.md_div ? DIV_CYCLES : MULT_CYCLES).
  - Else if md_count != 0: md_count ← md_count − 1.
- md_busy = (md_count != 0).

## Timing
- Reset (async, rst_n low):
  - E and M records cleared (wa = 0, tnew = 0, md flags 0).
  - md_count = 0.
  - Hence stall = 0 and md_busy = 0 as long as D inputs request nothing hazardous.
- Reset deassertion mid-sequence: no state survives; the first post-reset D instruction never stalls on prior producers.
- Load-use, one-instruction gap:
  - The consumer with Tuse 1 stalls 1 cycle.
  - The consumer with Tuse 0 (branch/jr) stalls 2 cycles.
- CAL producer immediately followed by a branch on its result: 1-cycle stall.
- Once the producer reaches M with tnew 0, stall clears.
- Store rt (Tuse 2) never stalls on a load in E; forwarding covers it.
- MD start in E plus any MDFT in D: stall that cycle. Then MDFT stalls until md_count returns to 0.
- Total MDFT stall after a mult in E = 1 + MULT_CYCLES cycles; after a div = 1 + DIV_CYCLES.
- A new md_start in E while md_count != 0 reloads the counter. This cannot occur architecturally because the MDFT stall prevents it; the assertion checks it never happens.
- Simultaneous data and MD stall: single stall; one bubble per stalled cycle.
- During stall the D inputs are held by the frozen F/D register; no handshake beyond that.

## Test plan
- Reset: drive rst_n low mid-stream with a load in E → stall=0, md_count=0 immediately (async); after release, an add using that load's register → no stall.
- Load-use: lw $3 then addu $4,$3,$5 → stall high exactly 1 cycle; lw $3 then beq $3,$0 → stall 2 cycles; lw $3, nop, beq $3 → stall 1 cycle.
- $0 and store: lw $0 then addu using $0 → no stall; lw $3 then sw $3,0($4) (rt) → no stall; lw $3 then sw $5,0($3) (rs) → 1 cycle.
- ALU to branch: addu $2 then bne $2,$1 → 1-cycle stall; addu $2, nop, bne $2 → no stall; jal then jr $31 → no stall.
- Mult/div: mult then mflo → stall 6 cycles, md_count sequence 5,4,3,2,1,0; div then mfhi → 11 cycles; div then addu (non-MDFT) → no stall, md_busy still counts.
- Combined: lw $8 in E, md_count=3, D = mthi $8 → stall until both conditions clear (3 cycles); stall deasserts the cycle md_count reaches 0.
